poly_arbiter: RTL and testbench
===============================

# poly_arbiter

Sequencer and round-robin arbiter that shares one 16-bit polynomial evaluator (computes A·X² + B·X + C, start/done handshake) among N requesters. Sits between the requesting units and the evaluator. It selects one request and latches that requester's operands, then pulses the evaluator start and waits for done. It then returns the result with a one-cycle acknowledge. A watchdog aborts any job whose evaluator never signals done.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 16, operand/result width
- TIMEOUT, 64, max cycles waited for ev_done before abort (≥4)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  request per requester; held high until its ack
- a_in, b_in, c_in, x_in  in  N_REQ·W each  packed operands, requester i at bits [i·W +: W]
- gnt  out  N_REQ  one-hot owner of the current job, 0 when idle
- ack  out  N_REQ  one-cycle completion pulse to the owner
- res_out  out  W  result, valid only while ack is high
- err  out  1  high with ack when the job timed out
- ev_start  out  1  one-cycle start to the evaluator
- ev_a, ev_b, ev_c, ev_x  out  W  latched operands, stable from START through RESP
- ev_res  in  W  evaluator result
- ev_done  in  1  evaluator completion; evaluator clears it on ev_start

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req is high, pick the winner by round robin: the first asserted index starting at ptr+1 mod N_REQ.
  - Latch gnt and the winner's operands into ev_*.
  - Set ptr = winner and go to START.
  - If no req is high, stay in IDLE.
- START:
  - ev_start = 1 for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - ev_done = 1: capture ev_res into res_out, err = 0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT−1: res_out = 0, err = 1, go to RESP.
  - Otherwise, increment the counter.
- RESP:
  - ack[owner] = 1 for one cycle; gnt is still asserted.
  - Next state is IDLE, with gnt cleared.
- Arbitration rules:
  - req changes outside IDLE are ignored.
  - A requester that drops req mid-job still receives its ack pulse.
  - A requester that keeps req high after ack is eligible again, but ptr has advanced past it, so other pending requesters win first.
- ev_done is sampled only in WAIT. A done seen in START or IDLE is ignored.
- Result arithmetic belongs to the evaluator: res_out is ev_res passed through unmodified (mod 2^W).
- Reset (asynchronous, any state):
  - state = IDLE, ptr = N_REQ−1 so that index 0 wins first.
  - gnt, ack, err, ev_start, res_out, ev_* and counter all 0.
  - An in-flight job is discarded with no ack. The evaluator shares rst.

## Timing
- req sampled at edge t0 (IDLE) → gnt and ev_* valid after t0.
- ev_start high during cycle t0+1.
- WAIT begins at t0+2.
- ev_done sampled high at edge tD → ack/res_out/err high in cycle tD+1 → IDLE at tD+2.
- Per-job overhead: 3 cycles plus evaluator latency.
- Back-to-back: the earliest next gnt is 1 cycle after ack (IDLE decision cycle).
- Worst case without done: ack with err at t0+2+TIMEOUT.
- All outputs registered. No combinational path from req or ev_done to any output.

## Structure
- Shared package poly_pkg:
  - state encoding localparams (IDLE/START/WAIT/RESP)
  - default W
  - TIMEOUT counter width, clog2(TIMEOUT)
- Sub-module rr_pick: combinational round-robin priority picker (req, ptr → one-hot grant, index, any). Reused by other shared-resource arbiters.

## Test plan
- Single job: reset, req[0]=1 with A=3, B=10, C=5, X=3 and a behavioral evaluator with 4-cycle latency → ev_start 1 cycle after the sample, ack[0] with res_out=62, err=0; gnt back to 0 after RESP.
- Simultaneous requests: req[0] and req[2] high together after reset → requester 0 served first, then 2; each gets exactly one ack.
- Fairness: all four req held high continuously → grant order 0,1,2,3,0,1; no requester served twice before the others.
- Timeout: the evaluator never asserts ev_done, TIMEOUT=64 → ack with err=1 and res_out=0 exactly 64 cycles after WAIT entry; the next request is served normally.
- Reset mid-job: assert rst during WAIT → all outputs 0 immediately with no ack. After release, req[1]=1 with A=1, B=0, C=0, X=300 → res_out=24464 (90000 mod 2^16).
- Stray done and dropped request: ev_done pulsed while IDLE is ignored (no ack). A requester dropping req during WAIT still gets its ack.

Source files
------------

// File: rtl/poly_arbiter_pkg.sv
// Shared definitions for the polynomial-evaluator arbiter: FSM states,
// default widths and the watchdog counter sizing helper.
package poly_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int DEF_W       = 16;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = $clog2(DEF_TIMEOUT);

    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/poly_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// ptr+1 (mod N), reported as one-hot grant, binary index and an any flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    int unsigned w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_pos = (32'(i_ptr) + k) % N;
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_idx        = PW'(w_pos);
                o_gnt[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_arbiter.sv
// Round-robin sequencer sharing one A*X^2+B*X+C evaluator among N_REQ
// requesters, with a watchdog that aborts jobs lacking ev_done.
module poly_arbiter
    import poly_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    input  logic [N_REQ*W-1:0] c_in,
    input  logic [N_REQ*W-1:0] x_in,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic [W-1:0]     res_out,
    output logic             err,
    output logic             ev_start,
    output logic [W-1:0]     ev_a,
    output logic [W-1:0]     ev_b,
    output logic [W-1:0]     ev_c,
    output logic [W-1:0]     ev_x,
    input  logic [W-1:0]     ev_res,
    input  logic             ev_done
);

    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [PW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_ack;
    logic [W-1:0]     r_res;
    logic             r_err;
    logic             r_ev_start;
    logic [W-1:0]     r_ev_a, r_ev_b, r_ev_c, r_ev_x;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_any;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PW'(N_REQ - 1);
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_res      <= '0;
            r_err      <= 1'b0;
            r_ev_start <= 1'b0;
            r_ev_a     <= '0;
            r_ev_b     <= '0;
            r_ev_c     <= '0;
            r_ev_x     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt      <= w_pick_gnt;
                        r_ptr      <= w_pick_idx;
                        r_ev_a     <= a_in[w_pick_idx*W +: W];
                        r_ev_b     <= b_in[w_pick_idx*W +: W];
                        r_ev_c     <= c_in[w_pick_idx*W +: W];
                        r_ev_x     <= x_in[w_pick_idx*W +: W];
                        r_ev_start <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_ev_start <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ev_done) begin
                        r_res   <= ev_res;
                        r_err   <= 1'b0;
                        r_ack   <= r_gnt;
                        r_state <= ST_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_res   <= '0;
                        r_err   <= 1'b1;
                        r_ack   <= r_gnt;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_ack   <= '0;
                    r_gnt   <= '0;
                    r_err   <= 1'b0;
                    r_res   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign ack      = r_ack;
    assign res_out  = r_res;
    assign err      = r_err;
    assign ev_start = r_ev_start;
    assign ev_a     = r_ev_a;
    assign ev_b     = r_ev_b;
    assign ev_c     = r_ev_c;
    assign ev_x     = r_ev_x;

endmodule

// File: tb/tb_poly_arbiter.sv
// Directed bench for poly_arbiter with a behavioural 4-cycle evaluator.
module tb_poly_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TO  = 64;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]   req, gnt, ack;
    logic [N*W-1:0] a_in, b_in, c_in, x_in;
    logic [W-1:0]   res_out, ev_a, ev_b, ev_c, ev_x, ev_res;
    logic           err, ev_start, ev_done;

    logic           m_done, stray_done, en_done;
    int unsigned    m_cnt;
    logic [W-1:0]   m_res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    poly_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .x_in(x_in),
        .gnt(gnt), .ack(ack), .res_out(res_out), .err(err),
        .ev_start(ev_start), .ev_a(ev_a), .ev_b(ev_b), .ev_c(ev_c), .ev_x(ev_x),
        .ev_res(ev_res), .ev_done(ev_done)
    );

    function automatic logic [W-1:0] poly(input logic [W-1:0] a, b, c, x);
        int unsigned t;
        t = 32'(a) * 32'(x) * 32'(x) + 32'(b) * 32'(x) + 32'(c);
        return t[W-1:0];
    endfunction

    // Evaluator model: done LAT cycles after start, cleared by the next start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
        end else if (ev_start) begin
            m_done <= 1'b0;
            m_cnt  <= LAT - 1;
            m_res  <= poly(ev_a, ev_b, ev_c, ev_x);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && en_done) m_done <= 1'b1;
        end
    end

    assign ev_done = m_done | stray_done;
    assign ev_res  = m_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_job(input logic [N-1:0] eg, input logic [W-1:0] ex,
                          input logic [W-1:0] eres, input logic eerr,
                          input int ecyc, input logic drop, input logic release_req);
        int n;
        n = 0;
        while (gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("gnt", 32'(gnt), 32'(eg));
        check("ev_start_high", 32'(ev_start), 1);
        check("ev_x_latched", 32'(ev_x), 32'(ex));
        @(negedge clk);
        n = 1;
        check("ev_start_pulse", 32'(ev_start), 0);
        if (drop) begin
            @(negedge clk);
            n++;
            req = req & ~eg;
        end
        while (ack == '0 && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        check("ack", 32'(ack), 32'(eg));
        check("res_out", 32'(res_out), 32'(eres));
        check("err", 32'(err), 32'(eerr));
        check("gnt_in_resp", 32'(gnt), 32'(eg));
        check("latency", 32'(n), 32'(ecyc));
        if (release_req) req = req & ~eg;
        @(negedge clk);
        check("gnt_cleared", 32'(gnt), 0);
        check("ack_pulse", 32'(ack), 0);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [W-1:0] x;
        logic [W-1:0] res;
    } vec_t;

    vec_t vt[6];
    logic [N-1:0] f_gnt[6];
    logic [W-1:0] f_x[6];
    logic [W-1:0] f_res[6];

    initial begin
        int seen;

        // Requester operands: 0 -> 62, 1 -> 24464, 2 -> 69, 3 -> 65533
        a_in = {16'hFFFF, 16'd2, 16'd1, 16'd3};
        b_in = {16'd0,    16'd3, 16'd0, 16'd10};
        c_in = {16'd1,    16'd4, 16'd0, 16'd5};
        x_in = {16'd2,    16'd5, 16'd300, 16'd3};

        vt[0] = '{req: 4'b0101, gnt: 4'b0001, x: 16'd3,   res: 16'd62};
        vt[1] = '{req: 4'b0100, gnt: 4'b0100, x: 16'd5,   res: 16'd69};
        vt[2] = '{req: 4'b1011, gnt: 4'b1000, x: 16'd2,   res: 16'd65533};
        vt[3] = '{req: 4'b0011, gnt: 4'b0001, x: 16'd3,   res: 16'd62};
        vt[4] = '{req: 4'b0010, gnt: 4'b0010, x: 16'd300, res: 16'd24464};
        vt[5] = '{req: 4'b0011, gnt: 4'b0001, x: 16'd3,   res: 16'd62};

        f_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        f_x   = '{16'd3, 16'd300, 16'd5, 16'd2, 16'd3, 16'd300};
        f_res = '{16'd62, 16'd24464, 16'd69, 16'd65533, 16'd62, 16'd24464};

        rst = 1'b1; req = '0; en_done = 1'b1; stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ev_start", 32'(ev_start), 0);
        check("rst_res", 32'(res_out), 0);
        check("rst_ev_a", 32'(ev_a), 0);
        rst = 1'b0;
        @(negedge clk);

        // Stray done while idle must not produce a job
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | int'(ack) | int'(gnt) | int'(ev_start);
        end
        check("stray_done_ignored", 32'(seen), 0);

        for (int i = 0; i < 6; i++) begin
            req = vt[i].req;
            do_job(vt[i].gnt, vt[i].x, vt[i].res, 1'b0, LAT + 1, 1'b0, 1'b1);
        end

        // Requester 2 drops req while its job is in flight
        req = 4'b0100;
        do_job(4'b0100, 16'd5, 16'd69, 1'b0, LAT + 1, 1'b1, 1'b1);
        check("dropped_req_low", 32'(req), 0);

        // Watchdog abort, then a normal job
        en_done = 1'b0;
        req = 4'b0001;
        do_job(4'b0001, 16'd3, 16'd0, 1'b1, TO + 1, 1'b0, 1'b1);
        en_done = 1'b1;
        req = 4'b0010;
        do_job(4'b0010, 16'd300, 16'd24464, 1'b0, LAT + 1, 1'b0, 1'b1);

        // Reset during WAIT
        req = 4'b0001;
        seen = 0;
        while (gnt == '0 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        check("midjob_gnt", 32'(gnt), 32'(4'b0001));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midjob_rst_gnt", 32'(gnt), 0);
        check("midjob_rst_ack", 32'(ack), 0);
        check("midjob_rst_ev_start", 32'(ev_start), 0);
        check("midjob_rst_ev_x", 32'(ev_x), 0);
        check("midjob_rst_err", 32'(err), 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | int'(ack) | int'(gnt);
        end
        check("midjob_no_ack", 32'(seen), 0);
        req = 4'b0010;
        do_job(4'b0010, 16'd300, 16'd24464, 1'b0, LAT + 1, 1'b0, 1'b1);

        // Fairness with all requests held continuously from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            do_job(f_gnt[i], f_x[i], f_res[i], 1'b0, LAT + 1, 1'b0, 1'b0);
        end
        req = '0;
        repeat (3) @(negedge clk);
        check("final_idle_gnt", 32'(gnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
